// File: rtl/dac_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_clk_pkg
// Description : Shared types and default constants for the DAC clock manager
//               (lock FSM state encoding, parameter defaults, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package dac_clk_pkg;

  // Lock sequencing states; width fixed so the encoding is explicit
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  localparam int NCH_DEFAULT       = 2;
  localparam int ACC_W_DEFAULT     = 24;
  localparam int LOCK_WAIT_DEFAULT = 1024;

  // Stability counter width: covers LOCK_WAIT up to 65535
  localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/dac_nco_ch.sv
`default_nettype none
// ============================================================================
// Module      : dac_nco_ch
// Description : One sample-strobe channel: double-buffered tuning word,
//               phase accumulator and registered carry-out strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_nco_ch
  import dac_clk_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             en,
  input  logic             update,
  input  logic [ACC_W-1:0] ftw,
  output logic             strobe
);

  logic [ACC_W-1:0] ftw_active;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // One extra bit captures the wrap of the modulo-2^ACC_W addition
  assign sum = {1'b0, acc} + {1'b0, ftw_active};

  // Tuning-word shadow load, accumulation and strobe on carry-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_active <= '0;
      acc        <= '0;
      strobe     <= 1'b0;
    end else begin
      // Loaded in every state so software can stage a rate before RUN
      if (update) begin
        ftw_active <= ftw;
      end
      if (run && en) begin
        acc    <= sum[ACC_W-1:0];
        strobe <= sum[ACC_W];
      end else begin
        acc    <= '0;
        strobe <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dac_clk_mgr.sv
`default_nettype none
// ============================================================================
// Module      : dac_clk_mgr
// Description : DAC clock manager. Synchronises the PLL lock flag, waits for
//               LOCK_WAIT cycles of continuous lock, then releases the
//               downstream reset and runs NCH phase-accumulator strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_clk_mgr
  import dac_clk_pkg::*;
#(
  parameter int NCH       = NCH_DEFAULT,
  parameter int ACC_W     = ACC_W_DEFAULT,
  parameter int LOCK_WAIT = LOCK_WAIT_DEFAULT
) (
  input  logic                 REFERENCECLK,
  input  logic                 RESET,
  input  logic                 LOCK,
  input  logic [NCH*ACC_W-1:0] FTW,
  input  logic                 UPDATE,
  input  logic [NCH-1:0]       EN,
  input  logic                 CLR_LOST,
  output logic                 RSTN_OUT,
  output logic                 READY,
  output logic [NCH-1:0]       STROBE,
  output logic                 LOCK_LOST
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  logic             lock_m;
  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             run;

  // Two-flop synchroniser for the asynchronous PLL lock flag
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= LOCK;
      lock_s <= lock_m;
    end
  end

  // Next-state and stability-counter logic; counter is zero outside STABILISE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) state_nxt = STABILISE;
      end
      STABILISE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = LOST;
      end
      LOST: begin
        state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase
  end

  // State, counter and registered RUN indicators (decoded from next state so
  // they rise in the same cycle the FSM enters RUN)
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      READY    <= 1'b0;
      RSTN_OUT <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      READY    <= (state_nxt == RUN);
      RSTN_OUT <= (state_nxt == RUN);
    end
  end

  // Sticky lock-loss flag; a new loss takes priority over a clear request
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      LOCK_LOST <= 1'b0;
    end else if (state == RUN && !lock_s) begin
      LOCK_LOST <= 1'b1;
    end else if (CLR_LOST) begin
      LOCK_LOST <= 1'b0;
    end
  end

  assign run = (state == RUN);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    dac_nco_ch #(
      .ACC_W (ACC_W)
    ) u_nco (
      .clk    (REFERENCECLK),
      .rst_n  (RESET),
      .run    (run),
      .en     (EN[i]),
      .update (UPDATE),
      .ftw    (FTW[i*ACC_W +: ACC_W]),
      .strobe (STROBE[i])
    );
  end

endmodule
`default_nettype wire
